// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types for the data-memory path.
//   mem_mode_t  - access mode encoding (shared with data memory and decoder)
//   dmem_req_t  - one captured access {we, addr, mode, wdata}
//   mode_size() - access size in bytes for a mode (4 for undefined modes)
package dmem_pkg;

    typedef enum logic [2:0] {
        BYTE              = 3'b000,
        HALFWORD          = 3'b001,
        WORD              = 3'b010,
        BYTE_UNSIGNED     = 3'b011,
        HALFWORD_UNSIGNED = 3'b100
    } mem_mode_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [2:0]  mode;   // raw field: undefined encodings must survive to the legality check
        logic [31:0] wdata;
    } dmem_req_t;

    function automatic logic [2:0] mode_size(input logic [2:0] mode);
        case (mode)
            BYTE, BYTE_UNSIGNED:         mode_size = 3'd1;
            HALFWORD, HALFWORD_UNSIGNED: mode_size = 3'd2;
            default:                     mode_size = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/dmem_rr_arb.sv
// dmem_rr_arb: 2-way round-robin arbiter with a bounded ownership lock.
//   clk, rst   - clock, asynchronous active-high reset
//   req[1:0]   - request per requester
//   lock[1:0]  - requester asks to keep ownership for its next access
//   gnt[1:0]   - combinational one-hot grant (0 while rst is high)
// A requester whose previous grant carried lock=1 keeps winning while it
// requests, until it has held LOCK_MAX consecutive grants; it then competes
// by plain round-robin so the other requester is served next.
module dmem_rr_arb #(
    parameter int LOCK_MAX = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] lock,
    output logic [1:0] gnt
);

    logic       rr_ptr;     // requester that wins a conflict
    logic       lock_vld;   // previous grant carried lock=1
    logic       lock_id;    // owner of that grant
    logic [3:0] lock_cnt;   // grants held in the current locked run
    logic       lock_hit;
    logic       gid;
    logic       any_gnt;

    always_comb begin
        lock_hit = lock_vld & req[lock_id] & (lock_cnt < 4'(LOCK_MAX));
        gnt      = 2'b00;
        if (rst) begin
            gnt = 2'b00;
        end else if (lock_hit) begin
            gnt = lock_id ? 2'b10 : 2'b01;
        end else if (req == 2'b11) begin
            gnt = rr_ptr ? 2'b10 : 2'b01;
        end else begin
            gnt = req;
        end
        gid     = gnt[1];
        any_gnt = |gnt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr   <= 1'b0;
            lock_vld <= 1'b0;
            lock_id  <= 1'b0;
            lock_cnt <= 4'd0;
        end else if (any_gnt) begin
            rr_ptr <= ~gid;
            if (lock[gid]) begin
                lock_vld <= 1'b1;
                lock_id  <= gid;
                // A grant won through round-robin starts a fresh locked run.
                lock_cnt <= lock_hit ? lock_cnt + 4'd1 : 4'd1;
            end else begin
                lock_vld <= 1'b0;
                lock_cnt <= 4'd0;
            end
        end else begin
            // Nobody requested, so the owner has dropped req.
            lock_vld <= 1'b0;
            lock_cnt <= 4'd0;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester arbiter/sequencer for the single-port,
// big-endian, byte-addressed data memory (async read, sync write).
//   clk, rst                 - clock, asynchronous active-high reset
//   req/lock/we/addr/mode/wdata [1:0] - per-requester access (0 = core, 1 = debug/DMA)
//   gnt[1:0]                 - one-hot accept this cycle
//   rsp_valid[1:0]           - one-cycle response pulse to the requester served
//   rsp_rdata, rsp_err       - load data / rejection flag, valid with rsp_valid
//   mem_rd_en, mem_wr_en, mem_addr, mem_acc_mode, mem_wdata, mem_rdata - memory port
// Handshake: a requester holds req and its access fields stable until it sees
// gnt; the access is taken in the cycle gnt is high and only the values
// present in that cycle are used. There is no backpressure after gnt.
// Pipeline: grant in N, memory access in N+1, response pulse in N+2.
// Illegal accesses travel the pipeline but never enable the memory.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int MEM_BYTES = 100,
    parameter int LOCK_MAX  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      req,
    input  logic [1:0]      lock,
    input  logic [1:0]      we,
    input  logic [1:0][31:0] addr,
    input  logic [1:0][2:0] mode,
    input  logic [1:0][31:0] wdata,
    output logic [1:0]      gnt,
    output logic [1:0]      rsp_valid,
    output logic [31:0]     rsp_rdata,
    output logic            rsp_err,
    output logic            mem_rd_en,
    output logic            mem_wr_en,
    output logic [31:0]     mem_addr,
    output logic [2:0]      mem_acc_mode,
    output logic [31:0]     mem_wdata,
    input  logic [31:0]     mem_rdata
);

    dmem_rr_arb #(.LOCK_MAX(LOCK_MAX)) u_arb (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .lock (lock),
        .gnt  (gnt)
    );

    // Accept stage: select the winner's fields and check legality.
    dmem_req_t  sel;
    logic       sel_id;
    logic       sel_err;
    logic [2:0] sel_size;
    logic [32:0] sel_end;

    always_comb begin
        sel_id    = gnt[1];
        sel.we    = we[sel_id];
        sel.addr  = addr[sel_id];
        sel.mode  = mode[sel_id];
        sel.wdata = wdata[sel_id];
        sel_size  = mode_size(sel.mode);
        // 33-bit end address so a huge addr cannot wrap into range.
        sel_end   = {1'b0, sel.addr} + {30'd0, sel_size};
        sel_err   = (sel.mode > 3'b100)
                  | (sel.we & ((sel.mode == BYTE_UNSIGNED) | (sel.mode == HALFWORD_UNSIGNED)))
                  | (((sel.mode == HALFWORD) | (sel.mode == HALFWORD_UNSIGNED)) & sel.addr[0])
                  | ((sel.mode == WORD) & (sel.addr[1:0] != 2'b00))
                  | (sel_end > 33'(MEM_BYTES));
    end

    // Issue register.
    logic      iss_vld;
    logic      iss_id;
    logic      iss_err;
    dmem_req_t iss;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss_vld <= 1'b0;
            iss_id  <= 1'b0;
            iss_err <= 1'b0;
            iss     <= '0;
        end else begin
            iss_vld <= |gnt;
            if (|gnt) begin
                iss_id  <= sel_id;
                iss_err <= sel_err;
                iss     <= sel;
            end
        end
    end

    assign mem_rd_en    = iss_vld & ~iss.we & ~iss_err;
    assign mem_wr_en    = iss_vld &  iss.we & ~iss_err;
    assign mem_addr     = iss.addr;
    assign mem_acc_mode = iss.mode;
    assign mem_wdata    = iss.wdata;

    // Response stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 2'b00;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'd0;
        end else begin
            rsp_valid <= iss_vld ? (iss_id ? 2'b10 : 2'b01) : 2'b00;
            rsp_err   <= iss_vld & iss_err;
            rsp_rdata <= mem_rd_en ? mem_rdata : 32'd0;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a behavioural
// big-endian data memory and a scoreboard of expected responses.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    localparam int MEM_BYTES = 100;
    localparam int LOCK_MAX  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req, lock, we;
    logic [1:0][31:0] addr, wdata;
    logic [1:0][2:0]  mode;
    logic [1:0]       gnt, rsp_valid;
    logic [31:0]      rsp_rdata;
    logic             rsp_err;
    logic             mem_rd_en, mem_wr_en;
    logic [31:0]      mem_addr, mem_wdata, mem_rdata;
    logic [2:0]       mem_acc_mode;

    dmem_arbiter #(.MEM_BYTES(MEM_BYTES), .LOCK_MAX(LOCK_MAX)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .lock         (lock),
        .we           (we),
        .addr         (addr),
        .mode         (mode),
        .wdata        (wdata),
        .gnt          (gnt),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_rd_en    (mem_rd_en),
        .mem_wr_en    (mem_wr_en),
        .mem_addr     (mem_addr),
        .mem_acc_mode (mem_acc_mode),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- data memory model ----------------
    logic [7:0]  mem [0:MEM_BYTES-1];
    logic [31:0] a1, a2, a3;
    logic [7:0]  b0, b1, b2, b3;
    int          wa;

    always_comb begin
        a1 = mem_addr + 32'd1;
        a2 = mem_addr + 32'd2;
        a3 = mem_addr + 32'd3;
        b0 = (mem_addr < 32'(MEM_BYTES)) ? mem[mem_addr[6:0]] : 8'h00;
        b1 = (a1 < 32'(MEM_BYTES)) ? mem[a1[6:0]] : 8'h00;
        b2 = (a2 < 32'(MEM_BYTES)) ? mem[a2[6:0]] : 8'h00;
        b3 = (a3 < 32'(MEM_BYTES)) ? mem[a3[6:0]] : 8'h00;
        case (mem_acc_mode)
            BYTE:              mem_rdata = {{24{b0[7]}}, b0};
            HALFWORD:          mem_rdata = {{16{b0[7]}}, b0, b1};
            WORD:              mem_rdata = {b0, b1, b2, b3};
            BYTE_UNSIGNED:     mem_rdata = {24'd0, b0};
            HALFWORD_UNSIGNED: mem_rdata = {16'd0, b0, b1};
            default:           mem_rdata = 32'd0;
        endcase
    end

    initial begin
        for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'(i);
        forever begin
            @(posedge clk);
            if (mem_wr_en) begin
                wa = int'(mem_addr);
                case (mem_acc_mode)
                    BYTE: mem[wa] <= mem_wdata[7:0];
                    HALFWORD: begin
                        mem[wa]   <= mem_wdata[15:8];
                        mem[wa+1] <= mem_wdata[7:0];
                    end
                    WORD: begin
                        mem[wa]   <= mem_wdata[31:24];
                        mem[wa+1] <= mem_wdata[23:16];
                        mem[wa+2] <= mem_wdata[15:8];
                        mem[wa+3] <= mem_wdata[7:0];
                    end
                    default: ;
                endcase
            end
        end
    end

    int en_cnt = 0;
    always @(negedge clk) if (mem_rd_en | mem_wr_en) en_cnt <= en_cnt + 1;

    // ---------------- scoreboard ----------------
    // Entry: {cycle of response, rsp_valid, rsp_err, rsp_rdata}
    logic [50:0] exp_q[$];
    logic [50:0] got_e, exp_e;
    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    task automatic push_exp(input logic id, input logic e_err, input logic [31:0] e_rdata);
        exp_q.push_back({16'(cyc + 2), (id ? 2'b10 : 2'b01), e_err, e_rdata});
    endtask

    always @(negedge clk) begin
        if (rsp_valid != 2'b00) begin
            got_e = {cyc[15:0], rsp_valid, rsp_err, rsp_rdata};
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 64'(got_e), 64'd0);
            end else begin
                exp_e = exp_q.pop_front();
                check("rsp", 64'(got_e), 64'(exp_e));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+1; returns at the next posedge+1 with req dropped.
    task automatic issue(input logic id, input logic w, input logic [31:0] a,
                         input logic [2:0] m, input logic [31:0] d,
                         input logic e_err, input logic [31:0] e_rdata);
        req[id]   = 1'b1;
        lock[id]  = 1'b0;
        we[id]    = w;
        addr[id]  = a;
        mode[id]  = m;
        wdata[id] = d;
        @(negedge clk);
        check("gnt", 64'(gnt), id ? 64'd2 : 64'd1);
        push_exp(id, e_err, e_rdata);
        @(posedge clk); #1;
        req[id] = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    logic [1:0] expg;
    logic [1:0] lock_seq [0:5];
    int         en_snap;

    initial begin
        lock_seq[0] = 2'b10; lock_seq[1] = 2'b10; lock_seq[2] = 2'b10;
        lock_seq[3] = 2'b10; lock_seq[4] = 2'b01; lock_seq[5] = 2'b10;
        rst = 1'b1; req = 2'b00; lock = 2'b00; we = 2'b00;
        addr = '0; mode = '0; wdata = '0;

        // Reset state, with both requesters asking.
        repeat (2) @(posedge clk);
        #1 req = 2'b11;
        @(negedge clk);
        check("rst_gnt", 64'(gnt), 64'd0);
        check("rst_rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'd0);
        check("rst_mem", 64'({mem_rd_en, mem_wr_en, mem_addr, mem_acc_mode}), 64'd0);
        check("rst_wdata", 64'(mem_wdata), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Round-robin: both request, no lock, r0 first after reset.
        addr[0] = 32'd0; addr[1] = 32'd4;
        mode[0] = WORD;  mode[1] = WORD;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            expg = (k % 2 == 1) ? 2'b10 : 2'b01;
            check("rr_gnt", 64'(gnt), 64'(expg));
            push_exp(expg[1], 1'b0, expg[1] ? 32'h04050607 : 32'h00010203);
            @(posedge clk); #1;
        end
        req = 2'b00;
        drain();

        // Lock: r1 locked holds LOCK_MAX grants, then r0 once, then r1 again.
        req = 2'b10; lock = 2'b10;
        for (int k = 0; k < 6; k++) begin
            if (k == 1) req = 2'b11;
            @(negedge clk);
            check("lock_gnt", 64'(gnt), 64'(lock_seq[k]));
            push_exp(lock_seq[k][1], 1'b0, lock_seq[k][1] ? 32'h04050607 : 32'h00010203);
            @(posedge clk); #1;
        end
        req = 2'b00; lock = 2'b00;
        drain();

        // Store then back-to-back load, plus legal boundary accesses.
        issue(1'b0, 1'b1, 32'd8,  WORD,          32'hDEADBEEF, 1'b0, 32'h0);
        issue(1'b0, 1'b0, 32'd8,  WORD,          32'h0,        1'b0, 32'hDEADBEEF);
        issue(1'b1, 1'b0, 32'd8,  HALFWORD,      32'h0,        1'b0, 32'hFFFFDEAD);
        issue(1'b1, 1'b0, 32'd96, WORD,          32'h0,        1'b0, 32'h60616263);
        issue(1'b1, 1'b0, 32'd99, BYTE_UNSIGNED, 32'h0,        1'b0, 32'h00000063);
        drain();

        // Illegal accesses: memory must stay idle.
        en_snap = en_cnt;
        issue(1'b0, 1'b0, 32'd5,   HALFWORD,      32'h0,  1'b1, 32'h0);
        issue(1'b1, 1'b0, 32'd98,  WORD,          32'h0,  1'b1, 32'h0);
        issue(1'b0, 1'b1, 32'd0,   BYTE_UNSIGNED, 32'hFF, 1'b1, 32'h0);
        issue(1'b1, 1'b0, 32'd100, BYTE_UNSIGNED, 32'h0,  1'b1, 32'h0);
        issue(1'b0, 1'b0, 32'd0,   3'b101,        32'h0,  1'b1, 32'h0);
        drain();
        check("err_no_mem_en", 64'(en_cnt - en_snap), 64'd0);

        // Byte store and signed/unsigned reload; rejected store left addr 0 alone.
        issue(1'b0, 1'b1, 32'd3, BYTE,          32'h00000080, 1'b0, 32'h0);
        issue(1'b0, 1'b0, 32'd3, BYTE,          32'h0,        1'b0, 32'hFFFFFF80);
        issue(1'b1, 1'b0, 32'd3, BYTE_UNSIGNED, 32'h0,        1'b0, 32'h00000080);
        issue(1'b1, 1'b0, 32'd0, BYTE,          32'h0,        1'b0, 32'h00000000);
        drain();

        // Reset right after a granted store: dropped, no write, no response.
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'd12; mode[0] = WORD;
        wdata[0] = 32'h11223344;
        @(negedge clk);
        check("rst_store_gnt", 64'(gnt), 64'd1);
        @(posedge clk); #1;
        req = 2'b00; rst = 1'b1;
        @(negedge clk);
        check("rst_drop", 64'({mem_wr_en, mem_rd_en, rsp_valid}), 64'd0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;

        // After reset r0 is favoured again; addr 12 keeps its old contents.
        we = 2'b00; addr[0] = 32'd12; addr[1] = 32'd16;
        mode[0] = WORD; mode[1] = WORD; req = 2'b11;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            expg = (k == 1) ? 2'b10 : 2'b01;
            check("post_rst_gnt", 64'(gnt), 64'(expg));
            push_exp(expg[1], 1'b0, expg[1] ? 32'h10111213 : 32'h0C0D0E0F);
            @(posedge clk); #1;
        end
        req = 2'b00;
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
